// File: rtl/axis_depacketizer_pkg.sv
// -----------------------------------------------------------------------------
// axis_depacketizer_pkg
// Shared types and default widths for the AXI4-Stream depacketizer.
//   state_t          : FSM state encoding (RUN, PAD, DROP).
//   DEF_*_WIDTH      : default widths for data, beat counter and status counters.
// -----------------------------------------------------------------------------
package axis_depacketizer_pkg;

  localparam int DEF_TDATA_WIDTH = 32;
  localparam int DEF_CNTR_WIDTH  = 32;
  localparam int DEF_STS_WIDTH   = 32;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PAD  = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage

// File: rtl/axis_pipe_reg.sv
// -----------------------------------------------------------------------------
// axis_pipe_reg
// One-stage valid/ready output register.
// Ports:
//   aclk, aresetn   : clock, synchronous active-low reset
//   load            : write din into the register (honoured only when can_load)
//   din             : data to load
//   can_load        : register is empty or being drained this cycle
//   m_axis_tready   : downstream ready
//   m_axis_tdata    : registered data
//   m_axis_tvalid   : registered valid
// -----------------------------------------------------------------------------
module axis_pipe_reg
  import axis_depacketizer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_TDATA_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  can_load,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid
);

  assign can_load = ~m_axis_tvalid | m_axis_tready;

  // Data only changes on a load, so a stalled beat stays stable on the bus.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (can_load) begin
      m_axis_tvalid <= load;
      if (load) begin
        m_axis_tdata <= din;
      end
    end
  end

endmodule

// File: rtl/axis_depacketizer.sv
// -----------------------------------------------------------------------------
// axis_depacketizer
// Receives tlast-framed AXI4-Stream packets and re-emits an unframed stream in
// which every packet is exactly cfg_data+1 beats: short packets are zero-padded,
// long packets have their tail dropped. Counts good/short/long packets.
// Ports:
//   aclk, aresetn              : clock, synchronous active-low reset
//   cfg_data                   : expected packet length minus one
//   s_axis_tready/tdata/tvalid/tlast : slave stream in
//   m_axis_tready/tdata/tvalid : master stream out (registered)
//   sts_good/sts_short/sts_long: wrapping packet counters
//   err_short/err_long         : one-cycle error pulses
// -----------------------------------------------------------------------------
module axis_depacketizer
  import axis_depacketizer_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int CNTR_WIDTH       = DEF_CNTR_WIDTH,
  parameter int STS_WIDTH        = DEF_STS_WIDTH
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic [STS_WIDTH-1:0]        sts_good,
  output logic [STS_WIDTH-1:0]        sts_short,
  output logic [STS_WIDTH-1:0]        sts_long,
  output logic                        err_short,
  output logic                        err_long
);

  state_t                      state, state_next;
  logic [CNTR_WIDTH-1:0]       cnt, cnt_next, len_reg, eff_len;
  logic                        can_load, load, accept, at_end;
  logic [AXIS_TDATA_WIDTH-1:0] load_data;
  logic                        good_det, short_det, long_det;

  // On the first beat len_reg has not latched yet, so compare against the
  // live cfg_data; afterwards the latched value shields us from cfg changes.
  assign eff_len = (cnt == '0) ? cfg_data : len_reg;
  assign at_end  = (cnt == eff_len);

  assign s_axis_tready = ((state == RUN) && can_load) || (state == DROP);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, beat counter and output-register load decisions.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    load_data  = '0;
    good_det   = 1'b0;
    short_det  = 1'b0;
    long_det   = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          load      = 1'b1;
          load_data = s_axis_tdata;
          if (s_axis_tlast && at_end) begin
            good_det = 1'b1;
            cnt_next = '0;
          end else if (s_axis_tlast) begin
            short_det  = 1'b1;
            cnt_next   = cnt + 1'b1;
            state_next = PAD;
          end else if (at_end) begin
            long_det   = 1'b1;
            cnt_next   = '0;
            state_next = DROP;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      PAD: begin
        // Zero beats; advance only when a pad beat actually enters the register.
        if (can_load) begin
          load = 1'b1;
          if (at_end) begin
            cnt_next   = '0;
            state_next = RUN;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      DROP: begin
        if (accept && s_axis_tlast) begin
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = RUN;
      end
    endcase
  end

  // Beat counter, latched length, status counters and error pulses.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt       <= '0;
      len_reg   <= '0;
      sts_good  <= '0;
      sts_short <= '0;
      sts_long  <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if ((state == RUN) && accept && (cnt == '0)) begin
        len_reg <= cfg_data;
      end
      if (good_det)  sts_good  <= sts_good + 1'b1;
      if (short_det) sts_short <= sts_short + 1'b1;
      if (long_det)  sts_long  <= sts_long + 1'b1;
      err_short <= short_det;
      err_long  <= long_det;
    end
  end

  axis_pipe_reg #(
    .DATA_WIDTH(AXIS_TDATA_WIDTH)
  ) u_out_reg (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .load         (load),
    .din          (load_data),
    .can_load     (can_load),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid)
  );

endmodule

// File: doc/axis_depacketizer.md
# axis_depacketizer

Receive side of the packetizer link: accepts AXI4-Stream packets framed by `s_axis_tlast`, checks each packet against the expected length `cfg_data + 1` beats, and re-emits an unframed continuous stream in which every packet is exactly `cfg_data + 1` beats long. Short packets are zero-padded, and the tail of long packets is discarded. Per-class packet counters and error pulses feed the status register bank. The block sits between the DMA/stream fabric and the downstream sample consumer.

## Interface
- `AXIS_TDATA_WIDTH`, default 32: data width.
- `CNTR_WIDTH`, default 32: beat counter and `cfg_data` width.
- `STS_WIDTH`, default 32: width of each status counter.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; synchronous, active-low; clock `aclk`.
- `cfg_data`  in  CNTR_WIDTH  expected packet length minus one.
- `s_axis_tready`  out  1  slave ready.
- `s_axis_tdata`  in  AXIS_TDATA_WIDTH  slave data.
- `s_axis_tvalid`  in  1  slave valid.
- `s_axis_tlast`  in  1  slave end of packet.
- `m_axis_tready`  in  1  master ready.
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  master data (registered).
- `m_axis_tvalid`  out  1  master valid (registered).
- `sts_good`  out  STS_WIDTH  count of correct-length packets.
- `sts_short`  out  STS_WIDTH  count of short packets.
- `sts_long`  out  STS_WIDTH  count of long packets.
- `err_short`  out  1  one-cycle pulse when a short packet is detected.
- `err_long`  out  1  one-cycle pulse when a long packet is detected.

## Operation
- Notation: `L = len_reg + 1`. `len_reg` latches `cfg_data` on the first accepted beat of each packet (`cnt == 0`). `cfg_data` changes mid-packet have no effect until the next packet.
- Beat index `cnt` is CNTR_WIDTH wide. The end-of-length test is `cnt == len_reg`, never `cnt + 1`, so all-ones `cfg_data` works without overflow.
- States: RUN, PAD, DROP.
- **RUN**
  - Beats are accepted when `s_axis_tvalid & s_axis_tready` and forwarded to the output register.
  - `tlast & cnt == len_reg`: good packet. `sts_good++`, `cnt <= 0`, stay in RUN.
  - `tlast & cnt < len_reg`: short packet. `sts_short++`, pulse `err_short`, `cnt <= cnt + 1`, go to PAD.
  - `~tlast & cnt == len_reg`: long packet. The beat is forwarded. `sts_long++`, pulse `err_long`, `cnt <= 0`, go to DROP.
  - Otherwise `cnt++`.
- **PAD**
  - `s_axis_tready = 0`.
  - Writes all-zero beats into the output register whenever it can load.
  - On the pad beat with `cnt == len_reg`: `cnt <= 0`, go to RUN.
- **DROP**
  - `s_axis_tready = 1`. Accepted beats are discarded and nothing is written to the output.
  - On an accepted beat with `tlast`: go to RUN with `cnt = 0`.
- A single-beat packet with `tlast` when `cfg_data = 0` counts as good.
- Status counters wrap modulo 2^STS_WIDTH.

## Timing
- Output register loads when `~m_axis_tvalid | m_axis_tready`; this is the "can load" condition.
- `s_axis_tready = (state == RUN & can_load) | state == DROP`. It is combinational from `m_axis_tready` and the registered state.
- Latency: an accepted beat appears on `m_axis_*` on the next cycle. Full throughput is one beat per cycle with `m_axis_tready` held high.
- `m_axis_tvalid` / `m_axis_tdata` hold stable while `m_axis_tvalid & ~m_axis_tready`.
- Counters and `err_*` update on the cycle after the detecting handshake edge. `err_*` is high for exactly one cycle.
- Reset values:
  - State RUN; `cnt`, `len_reg` = 0.
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0.
  - `sts_*` = 0, `err_*` = 0.
  - `s_axis_tready` = 1 one cycle after reset release, because the output register is empty.
- Reset mid-PAD or mid-DROP: return to RUN with `cnt = 0`. The pending output beat is lost.
- Stall: the transition from PAD back to RUN happens only when the final pad beat is actually loaded.

## Structure
- Shared package `axis_depacketizer_pkg` holds:
  - state enum {RUN, PAD, DROP}, 2 bits;
  - width localparams.
- Sub-module `axis_pipe_reg`: one-stage valid/ready output register. Parameterized by data width; ports load enable and data in, master side out.
- Top-level contents: FSM, beat counter, `len_reg`, status counters.

## Test plan
- Good packets: `cfg_data = 3`, three back-to-back 4-beat packets (data 1..12), `m_axis_tready = 1`.
  - Required: output 1..12 contiguous with no bubbles.
  - Required: `sts_good = 3`, `sts_short = sts_long = 0`, and the first output beat 1 cycle after the first input handshake.
- Short packet: `cfg_data = 3`, packet A,B with `tlast` on B, then a good packet.
  - Required: output A,B,0,0, then the good packet.
  - Required: `err_short` pulses once, `sts_short = 1`, and `s_axis_tready = 0` for the 2 pad cycles.
- Long packet: `cfg_data = 1`, 5-beat packet 10..14.
  - Required: output 10,11; 12..14 accepted and dropped.
  - Required: `sts_long = 1`, `err_long` one pulse, next packet forwarded intact.
- Backpressure: `cfg_data = 7`, `m_axis_tready` toggling pseudo-randomly.
  - Required: no beat lost or duplicated.
  - Required: `m_axis_tdata` stable while stalled, also during a PAD sequence.
- Config change mid-packet: `cfg_data` 3→1 after beat 2 of a 4-beat packet.
  - Required: that packet counts as good; the next 2-beat packet also counts as good.
- Reset mid-DROP, plus `cfg_data = 0` single-beat packets afterwards.
  - Required: all outputs and counters return to 0.
  - Required: each single-beat `tlast` packet increments `sts_good`.
